// File: rtl/door_input_conditioner_pkg.sv
// Shared constants for the door input conditioner: parameter defaults and
// synchronizer depth.
package door_input_conditioner_pkg;

  localparam int unsigned DbCyclesDefault      = 8;
  localparam int unsigned HoldoffCyclesDefault = 16;
  localparam int unsigned SyncStages           = 2;

endpackage

// File: rtl/door_input_conditioner_if.sv
// Raw wall/limit/sensor inputs and conditioned outputs of the door input conditioner.
interface door_input_conditioner_if;

  logic b_raw;
  logic c_raw;
  logic o_raw;
  logic s_raw;
  logic b;
  logic c;
  logic o;
  logic s;
  logic fault;

  // Master drives the raw inputs; slave is the conditioner itself.
  modport master (
    output b_raw, c_raw, o_raw, s_raw,
    input  b, c, o, s, fault
  );

  modport slave (
    input  b_raw, c_raw, o_raw, s_raw,
    output b, c, o, s, fault
  );

endinterface

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer followed by a stable-count debouncer.
module debounce_channel
  import door_input_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic y_o,
  output logic db_o
);

  localparam int unsigned CntW = $clog2(DB_CYCLES) + 1;

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  db_q, db_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  y;

  assign y = sync_q[SyncStages-1];

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], raw_i};
    db_d   = db_q;
    cnt_d  = cnt_q;
    if (y == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
      db_d  = y;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y_o  = y;
  assign db_o = db_q;

endmodule

// File: rtl/door_input_conditioner.sv
// Conditions wall button, limit switches and obstruction sensor for the opener FSM:
// debounced levels, a rate-limited press pulse, safety-biased obstruction and limit fault.
module door_input_conditioner
  import door_input_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = DbCyclesDefault,
  parameter int unsigned HOLDOFF_CYCLES = HoldoffCyclesDefault
) (
  input logic                     clk,
  input logic                     r,
  door_input_conditioner_if.slave bus
);

  localparam int unsigned HoldW = $clog2(HOLDOFF_CYCLES) + 1;

  logic y_b, y_c, y_o, y_s;
  logic db_b, db_c, db_o, db_s;

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch_b (
    .clk_i(clk), .rst_i(r), .raw_i(bus.b_raw), .y_o(y_b), .db_o(db_b)
  );
  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch_c (
    .clk_i(clk), .rst_i(r), .raw_i(bus.c_raw), .y_o(y_c), .db_o(db_c)
  );
  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch_o (
    .clk_i(clk), .rst_i(r), .raw_i(bus.o_raw), .y_o(y_o), .db_o(db_o)
  );
  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch_s (
    .clk_i(clk), .rst_i(r), .raw_i(bus.s_raw), .y_o(y_s), .db_o(db_s)
  );

  logic unused_y;
  assign unused_y = ^{y_b, y_c, y_o};

  logic             db_b_prev_q;
  logic             b_q, b_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             c_q, c_d, o_q, o_d, s_q, s_d, fault_q, fault_d;
  logic             both_limits;

  always_comb begin
    both_limits = db_c & db_o;
    // Presses during holdoff are dropped outright, not deferred.
    b_d    = db_b & ~db_b_prev_q & (hold_q == '0);
    hold_d = hold_q;
    if (b_d) begin
      hold_d = HoldW'(HOLDOFF_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HoldW'(1);
    end
    // Contradictory limits freeze the reported levels rather than pass them on.
    c_d     = both_limits ? c_q : db_c;
    o_d     = both_limits ? o_q : db_o;
    s_d     = y_s | db_s;
    fault_d = both_limits;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      db_b_prev_q <= 1'b0;
      b_q         <= 1'b0;
      hold_q      <= '0;
      c_q         <= 1'b0;
      o_q         <= 1'b0;
      s_q         <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      db_b_prev_q <= db_b;
      b_q         <= b_d;
      hold_q      <= hold_d;
      c_q         <= c_d;
      o_q         <= o_d;
      s_q         <= s_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.b     = b_q;
  assign bus.c     = c_q;
  assign bus.o     = o_q;
  assign bus.s     = s_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_door_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output-change events {cycle, b c o s fault};
// a negedge monitor pops and compares each observed change.
module tb_door_input_conditioner;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       r;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic [4:0] prev = '0;
  exp_t       exp_q[$];

  door_input_conditioner_if dif ();

  door_input_conditioner #(
    .DB_CYCLES     (8),
    .HOLDOFF_CYCLES(16)
  ) dut (
    .clk(clk),
    .r  (r),
    .bus(dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] outs();
    return {dif.b, dif.c, dif.o, dif.s, dif.fault};
  endfunction

  task automatic expect_ev(input int c, input logic [4:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [4:0] v;
    exp_t       e;
    if (mon_en) begin
      v = outs();
      if (v !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got cyc %0d bcosf %b, required no change", cyc, v);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.vec !== v) begin
            errors++;
            $display("FAIL %s: got cyc %0d bcosf %b, required cyc %0d bcosf %b",
                     e.name, cyc, v, e.cyc, e.vec);
          end
        end
        prev = v;
      end
    end
  end

  initial begin
    int t;
    r         = 1'b1;
    dif.b_raw = 1'b0;
    dif.c_raw = 1'b0;
    dif.o_raw = 1'b0;
    dif.s_raw = 1'b0;
    step(3);
    r = 1'b0;
    step(1);
    checks++;
    if (outs() !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: got bcosf %b, required 00000", outs());
    end
    mon_en = 1'b1;
    prev   = 5'b00000;

    // Bouncing button then a long hold: one pulse 11 edges after the final rise.
    step(2);
    dif.b_raw = 1'b1; step(2);
    dif.b_raw = 1'b0; step(2);
    dif.b_raw = 1'b1; step(2);
    dif.b_raw = 1'b0; step(2);
    dif.b_raw = 1'b1;
    t = cyc;
    expect_ev(t + 11, 5'b10000, "bounce_pulse");
    expect_ev(t + 12, 5'b00000, "bounce_pulse_end");
    step(40);
    dif.b_raw = 1'b0;
    step(30);

    // Press, quick re-press whose db rise lands inside holdoff, then a late press.
    t = cyc;
    dif.b_raw = 1'b1;
    expect_ev(t + 11, 5'b10000, "press1_pulse");
    expect_ev(t + 12, 5'b00000, "press1_end");
    step(8);
    dif.b_raw = 1'b0; step(8);
    dif.b_raw = 1'b1; step(14);
    dif.b_raw = 1'b0; step(26);
    t = cyc;
    dif.b_raw = 1'b1;
    expect_ev(t + 11, 5'b10000, "press3_pulse");
    expect_ev(t + 12, 5'b00000, "press3_end");
    step(14);
    dif.b_raw = 1'b0;
    step(30);

    // Obstruction: one-cycle blip, then a long assertion with debounced release.
    t = cyc;
    dif.s_raw = 1'b1;
    expect_ev(t + 3, 5'b00010, "s_blip_rise");
    expect_ev(t + 4, 5'b00000, "s_blip_fall");
    step(1);
    dif.s_raw = 1'b0;
    step(10);
    t = cyc;
    dif.s_raw = 1'b1;
    expect_ev(t + 3, 5'b00010, "s_long_rise");
    step(20);
    dif.s_raw = 1'b0;
    expect_ev(cyc + 11, 5'b00000, "s_long_fall");
    step(20);

    // Closed limit, then both limits active -> fault with held levels.
    t = cyc;
    dif.c_raw = 1'b1;
    expect_ev(t + 11, 5'b01000, "c_rise");
    step(20);
    t = cyc;
    dif.o_raw = 1'b1;
    expect_ev(t + 11, 5'b01001, "fault_set");
    step(20);
    dif.o_raw = 1'b0;
    expect_ev(cyc + 11, 5'b01000, "fault_clear");
    step(20);

    // Reset with c_raw still high: full latency again from the first free edge.
    r = 1'b1;
    expect_ev(cyc + 1, 5'b00000, "reset_clear");
    step(1);
    r = 1'b0;
    expect_ev(cyc + 11, 5'b01000, "c_after_reset");
    step(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d events still pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
